// File: rtl/clk_div_ctrl.sv
// rtl/clk_div_ctrl.sv - programmable integer clock divider with period-aligned ratio/enable changes.
// Optional tick statistics counter enabled by macro CLK_DIV_CTRL_STAT_EN.
module clk_div_ctrl #(
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             div_out,
  output logic             tick,
  output logic [CNT_W-1:0] cur_div,
  output logic             busy
`ifdef CLK_DIV_CTRL_STAT_EN
  ,
  output logic [15:0]      stat_ticks
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, PEND, DRAIN} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cur_div_q, cur_div_d;
  logic [CNT_W-1:0] pend_div_q, pend_div_d;
  logic             pend_vld_q, pend_vld_d;
  logic             div_out_q, div_out_d;
  logic             tick_q, tick_d;
  logic             cfg_ready_q, cfg_ready_d;
  logic             cfg_err_q, cfg_err_d;

  logic             hs, legal, wrap;
  logic [CNT_W-1:0] cnt_inc;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cur_div_d  = cur_div_q;
    pend_div_d = pend_div_q;
    pend_vld_d = pend_vld_q;

    hs      = cfg_valid && cfg_ready_q;
    legal   = cfg_div >= CNT_W'(2);
    wrap    = (state_q != IDLE) && (cnt_q == cur_div_q - CNT_W'(1));
    cnt_inc = wrap ? '0 : cnt_q + CNT_W'(1);

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (hs && legal) cur_div_d = cfg_div;
        if (en) state_d = RUN;
      end
      RUN: begin
        cnt_d = cnt_inc;
        if (wrap) begin
          if (hs && legal) cur_div_d = cfg_div;
          if (!en) state_d = IDLE;
        end else if (hs && legal) begin
          pend_div_d = cfg_div;
          pend_vld_d = 1'b1;
          state_d    = en ? PEND : DRAIN;
        end else if (!en) begin
          state_d = DRAIN;
        end
      end
      PEND: begin
        cnt_d = cnt_inc;
        if (wrap) begin
          cur_div_d  = pend_div_q;
          pend_vld_d = 1'b0;
          state_d    = en ? RUN : IDLE;
        end else if (!en) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        cnt_d = cnt_inc;
        if (wrap) begin
          if (pend_vld_q) cur_div_d = pend_div_q;
          pend_vld_d = 1'b0;
          state_d    = en ? RUN : IDLE;
        end else if (en) begin
          state_d = pend_vld_q ? PEND : RUN;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs are decoded from next state so they line up with the registered counter.
    cfg_err_d   = hs && !legal;
    div_out_d   = (state_d != IDLE) && (cnt_d < (cur_div_d >> 1));
    tick_d      = (state_d != IDLE) && (cnt_d == cur_div_d - CNT_W'(1));
    cfg_ready_d = (state_d == IDLE) || (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cur_div_q   <= CNT_W'(DEFAULT_DIV);
      pend_div_q  <= '0;
      pend_vld_q  <= 1'b0;
      div_out_q   <= 1'b0;
      tick_q      <= 1'b0;
      cfg_ready_q <= 1'b1;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cur_div_q   <= cur_div_d;
      pend_div_q  <= pend_div_d;
      pend_vld_q  <= pend_vld_d;
      div_out_q   <= div_out_d;
      tick_q      <= tick_d;
      cfg_ready_q <= cfg_ready_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign cfg_ready = cfg_ready_q;
  assign cfg_err   = cfg_err_q;
  assign div_out   = div_out_q;
  assign tick      = tick_q;
  assign cur_div   = cur_div_q;

`ifdef CLK_DIV_CTRL_STAT_EN
  logic [15:0] stat_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_q <= '0;
    end else if (tick_q && (stat_q != 16'hFFFF)) begin
      stat_q <= stat_q + 16'd1;
    end
  end

  assign stat_ticks = stat_q;
`endif

endmodule
